// File: rtl/reduction_checker.sv
// Passive checker: recomputes a reduction of in1 and compares it with the DUT's out LATENCY cycles later.
// Latency: expected value delayed LATENCY cycles; mismatch, counter and captures register one cycle after the compare.
// Backpressure: none; observes every CLK edge and never stalls the DUT.
module reduction_checker #(
   parameter int WIDTH   = 4,
   parameter int LATENCY = 0,
   parameter int MODE    = 0,
   parameter int CNT_W   = 8
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic             en,
   input  logic             clear,
   input  logic [WIDTH-1:0] in1,
   input  logic             out,
   output logic             mismatch,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_count,
   output logic             first_err_exp,
   output logic [3:0]       first_err_tag,
   output logic             checking
);

   localparam logic [3:0] LAT4 = 4'(LATENCY);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] fill_cnt, fill_nxt;
   logic [3:0] cyc_cnt;
   logic       sync_q1, rst_n_sync;
   logic       exp_now, dly_exp, dly_vld, cmp_fail;

   // Reset asserts immediately, deasserts two CLK edges after ASYNCRESETN rises.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         sync_q1    <= 1'b0;
         rst_n_sync <= 1'b0;
      end else begin
         sync_q1    <= 1'b1;
         rst_n_sync <= sync_q1;
      end
   end

   // Expected value of the selected reduction for the current in1 sample.
   always_comb begin
      exp_now = 1'b0;
      case (MODE)
         0:       exp_now = (|in1) && (&in1);
         1:       exp_now = &in1;
         2:       exp_now = |in1;
         default: exp_now = ^in1;
      endcase
   end

   generate
      if (LATENCY == 0) begin : g_no_delay
         // With no pipeline the current sample is compared in the same cycle.
         assign dly_exp = exp_now;
         assign dly_vld = en;
      end else begin : g_delay
         logic [LATENCY-1:0] exp_sr;
         logic [LATENCY-1:0] vld_sr;

         // Delay line: each stage carries the expected bit and whether en was high when it was pushed.
         always_ff @(posedge CLK or negedge rst_n_sync) begin
            if (!rst_n_sync) begin
               exp_sr <= '0;
               vld_sr <= '0;
            end else if (clear) begin
               exp_sr <= '0;
               vld_sr <= '0;
            end else begin
               exp_sr[0] <= exp_now;
               vld_sr[0] <= en;
               for (int i = 1; i < LATENCY; i++) begin
                  exp_sr[i] <= exp_sr[i-1];
                  vld_sr[i] <= vld_sr[i-1];
               end
            end
         end

         assign dly_exp = exp_sr[LATENCY-1];
         assign dly_vld = vld_sr[LATENCY-1];
      end
   endgenerate

   // A compare happens whenever the emerging slot is valid, in any state, so in-flight samples drain.
   assign cmp_fail = dly_vld && !clear && (out !== dly_exp);

   // State register and fill counter.
   always_ff @(posedge CLK or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         state    <= IDLE;
         fill_cnt <= '0;
      end else begin
         state    <= state_nxt;
         fill_cnt <= fill_nxt;
      end
   end

   // Next state: FILL counts valid pushes until the line holds LATENCY of them.
   always_comb begin
      state_nxt = state;
      fill_nxt  = fill_cnt;
      if (clear) begin
         state_nxt = IDLE;
         fill_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  fill_nxt  = 4'd1;
                  state_nxt = (LATENCY <= 1) ? CHECK : FILL;
               end
            end
            FILL: begin
               if (!en) begin
                  state_nxt = IDLE;
                  fill_nxt  = '0;
               end else begin
                  fill_nxt = fill_cnt + 4'd1;
                  if (fill_cnt + 4'd1 == LAT4) state_nxt = CHECK;
               end
            end
            CHECK: begin
               if (!en) begin
                  state_nxt = IDLE;
                  fill_nxt  = '0;
               end
            end
            default: begin
               state_nxt = IDLE;
               fill_nxt  = '0;
            end
         endcase
      end
   end

   // Free-running slot tag and the registered CHECK indicator.
   always_ff @(posedge CLK or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         cyc_cnt  <= '0;
         checking <= 1'b0;
      end else if (clear) begin
         cyc_cnt  <= '0;
         checking <= 1'b0;
      end else begin
         cyc_cnt  <= cyc_cnt + 4'd1;
         checking <= (state == CHECK);
      end
   end

   // Error reporting: pulse, saturating count, sticky flag and first-failure capture.
   always_ff @(posedge CLK or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         mismatch      <= 1'b0;
         err_sticky    <= 1'b0;
         err_count     <= '0;
         first_err_exp <= 1'b0;
         first_err_tag <= '0;
      end else if (clear) begin
         mismatch      <= 1'b0;
         err_sticky    <= 1'b0;
         err_count     <= '0;
         first_err_exp <= 1'b0;
         first_err_tag <= '0;
      end else begin
         mismatch <= cmp_fail;
         if (cmp_fail) begin
            if (err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;
            if (!err_sticky) begin
               err_sticky    <= 1'b1;
               first_err_exp <= dly_exp;
               first_err_tag <= cyc_cnt;
            end
         end
      end
   end

endmodule

// File: tb/tb_reduction_checker.sv
// Directed-vector bench for reduction_checker across four parameter sets sharing one stimulus bus.
// d0: L=0 MODE0, d1: L=0 MODE1, d2: L=2 MODE2 CNT_W=2, d3: L=1 MODE3.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_reduction_checker;

   logic       CLK = 1'b0;
   logic       rst_n, en, clear;
   logic [3:0] in1;
   logic       o0, o1, o2, o3;

   logic       mm0, st0, fe0, ck0;  logic [7:0] cnt0;  logic [3:0] ft0;
   logic       mm1, st1, fe1, ck1;  logic [7:0] cnt1;  logic [3:0] ft1;
   logic       mm2, st2, fe2, ck2;  logic [1:0] cnt2;  logic [3:0] ft2;
   logic       mm3, st3, fe3, ck3;  logic [7:0] cnt3;  logic [3:0] ft3;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   reduction_checker #(.WIDTH(4), .LATENCY(0), .MODE(0), .CNT_W(8)) d0 (
      .CLK(CLK), .ASYNCRESETN(rst_n), .en(en), .clear(clear), .in1(in1), .out(o0),
      .mismatch(mm0), .err_sticky(st0), .err_count(cnt0), .first_err_exp(fe0),
      .first_err_tag(ft0), .checking(ck0));

   reduction_checker #(.WIDTH(4), .LATENCY(0), .MODE(1), .CNT_W(8)) d1 (
      .CLK(CLK), .ASYNCRESETN(rst_n), .en(en), .clear(clear), .in1(in1), .out(o1),
      .mismatch(mm1), .err_sticky(st1), .err_count(cnt1), .first_err_exp(fe1),
      .first_err_tag(ft1), .checking(ck1));

   reduction_checker #(.WIDTH(4), .LATENCY(2), .MODE(2), .CNT_W(2)) d2 (
      .CLK(CLK), .ASYNCRESETN(rst_n), .en(en), .clear(clear), .in1(in1), .out(o2),
      .mismatch(mm2), .err_sticky(st2), .err_count(cnt2), .first_err_exp(fe2),
      .first_err_tag(ft2), .checking(ck2));

   reduction_checker #(.WIDTH(4), .LATENCY(1), .MODE(3), .CNT_W(8)) d3 (
      .CLK(CLK), .ASYNCRESETN(rst_n), .en(en), .clear(clear), .in1(in1), .out(o3),
      .mismatch(mm3), .err_sticky(st3), .err_count(cnt3), .first_err_exp(fe3),
      .first_err_tag(ft3), .checking(ck3));

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Leaves the bench just after the clearing edge, with en low.
   task automatic do_clear();
      clear = 1'b1;
      en    = 1'b0;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; en = 1'b0; clear = 1'b0; in1 = 4'h0;
      o0 = 1'b0; o1 = 1'b0; o2 = 1'b0; o3 = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      n_vec++; if (mm0 !== 1'b0)    begin n_err++; $display("FAIL rst_mm0 got %b want 0", mm0); end
      n_vec++; if (st0 !== 1'b0)    begin n_err++; $display("FAIL rst_st0 got %b want 0", st0); end
      n_vec++; if (cnt0 !== 8'd0)   begin n_err++; $display("FAIL rst_cnt0 got %0d want 0", cnt0); end
      n_vec++; if (fe0 !== 1'b0)    begin n_err++; $display("FAIL rst_fe0 got %b want 0", fe0); end
      n_vec++; if (ft0 !== 4'd0)    begin n_err++; $display("FAIL rst_ft0 got %0d want 0", ft0); end
      n_vec++; if (ck0 !== 1'b0)    begin n_err++; $display("FAIL rst_ck0 got %b want 0", ck0); end
      n_vec++; if (cnt2 !== 2'd0)   begin n_err++; $display("FAIL rst_cnt2 got %0d want 0", cnt2); end
      n_vec++; if (ck2 !== 1'b0)    begin n_err++; $display("FAIL rst_ck2 got %b want 0", ck2); end
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      n_vec++; if (mm0 !== 1'b0 || ck0 !== 1'b0) begin n_err++; $display("FAIL idle_d0 got mm=%b ck=%b want 0/0", mm0, ck0); end
   endtask

   task automatic test_l0_modes();
      do_clear();
      en = 1'b1; in1 = 4'hF; o0 = 1'b1; o1 = 1'b1; tick();
      n_vec++; if (mm0 !== 1'b0) begin n_err++; $display("FAIL l0_F_mm0 got %b want 0", mm0); end
      n_vec++; if (mm1 !== 1'b0) begin n_err++; $display("FAIL l0_F_mm1 got %b want 0", mm1); end
      in1 = 4'h0; o0 = 1'b0; o1 = 1'b0; tick();
      n_vec++; if (mm0 !== 1'b0) begin n_err++; $display("FAIL l0_0_mm0 got %b want 0", mm0); end
      n_vec++; if (ck0 !== 1'b1) begin n_err++; $display("FAIL l0_ck0 got %b want 1", ck0); end
      in1 = 4'h7; o0 = 1'b0; o1 = 1'b1; tick();
      n_vec++; if (mm0 !== 1'b0)  begin n_err++; $display("FAIL l0_7_mm0 got %b want 0", mm0); end
      n_vec++; if (cnt0 !== 8'd0) begin n_err++; $display("FAIL l0_7_cnt0 got %0d want 0", cnt0); end
      n_vec++; if (mm1 !== 1'b1)  begin n_err++; $display("FAIL and_7_mm1 got %b want 1", mm1); end
      n_vec++; if (cnt1 !== 8'd1) begin n_err++; $display("FAIL and_7_cnt1 got %0d want 1", cnt1); end
      in1 = 4'h7; o0 = 1'b1; o1 = 1'b0; tick();
      n_vec++; if (mm0 !== 1'b1)  begin n_err++; $display("FAIL l0_bad_mm0 got %b want 1", mm0); end
      n_vec++; if (cnt0 !== 8'd1) begin n_err++; $display("FAIL l0_bad_cnt0 got %0d want 1", cnt0); end
      n_vec++; if (st0 !== 1'b1)  begin n_err++; $display("FAIL l0_bad_st0 got %b want 1", st0); end
      n_vec++; if (fe0 !== 1'b0)  begin n_err++; $display("FAIL l0_bad_fe0 got %b want 0", fe0); end
      n_vec++; if (ft0 !== 4'd3)  begin n_err++; $display("FAIL l0_bad_ft0 got %0d want 3", ft0); end
      n_vec++; if (mm1 !== 1'b0)  begin n_err++; $display("FAIL and_ok_mm1 got %b want 0", mm1); end
      in1 = 4'hF; o0 = 1'b1; tick();
      n_vec++; if (mm0 !== 1'b0 || cnt0 !== 8'd1) begin n_err++; $display("FAIL l0_after got mm=%b cnt=%0d want 0/1", mm0, cnt0); end
      en = 1'b0;
   endtask

   task automatic test_l2_or();
      do_clear();
      en = 1'b1; in1 = 4'h1; o2 = 1'bx; tick();
      n_vec++; if (mm2 !== 1'b0) begin n_err++; $display("FAIL fill1_mm2 got %b want 0", mm2); end
      in1 = 4'h0; o2 = 1'bx; tick();
      n_vec++; if (mm2 !== 1'b0) begin n_err++; $display("FAIL fill2_mm2 got %b want 0", mm2); end
      n_vec++; if (ck2 !== 1'b0) begin n_err++; $display("FAIL fill2_ck2 got %b want 0", ck2); end
      o2 = 1'b0; tick();
      n_vec++; if (mm2 !== 1'b1)  begin n_err++; $display("FAIL or_mm2 got %b want 1", mm2); end
      n_vec++; if (st2 !== 1'b1)  begin n_err++; $display("FAIL or_st2 got %b want 1", st2); end
      n_vec++; if (cnt2 !== 2'd1) begin n_err++; $display("FAIL or_cnt2 got %0d want 1", cnt2); end
      n_vec++; if (fe2 !== 1'b1)  begin n_err++; $display("FAIL or_fe2 got %b want 1", fe2); end
      n_vec++; if (ft2 !== 4'd2)  begin n_err++; $display("FAIL or_ft2 got %0d want 2", ft2); end
      n_vec++; if (ck2 !== 1'b1)  begin n_err++; $display("FAIL or_ck2 got %b want 1", ck2); end
      o2 = 1'b0; tick();
      n_vec++; if (mm2 !== 1'b0 || cnt2 !== 2'd1) begin n_err++; $display("FAIL or_next got mm=%b cnt=%0d want 0/1", mm2, cnt2); end
      en = 1'b0;
   endtask

   task automatic test_drain();
      do_clear();
      en = 1'b1; in1 = 4'h1; o2 = 1'bx; tick(); tick();
      o2 = 1'b1; tick();
      n_vec++; if (mm2 !== 1'b0) begin n_err++; $display("FAIL drain_a got %b want 0", mm2); end
      en = 1'b0; o2 = 1'b1; tick();
      n_vec++; if (mm2 !== 1'b0) begin n_err++; $display("FAIL drain_b got %b want 0", mm2); end
      o2 = 1'b0; tick();
      n_vec++; if (mm2 !== 1'b1 || cnt2 !== 2'd1) begin n_err++; $display("FAIL drain_last got mm=%b cnt=%0d want 1/1", mm2, cnt2); end
      n_vec++; if (ck2 !== 1'b0) begin n_err++; $display("FAIL drain_ck2 got %b want 0", ck2); end
      tick();
      n_vec++; if (mm2 !== 1'b0 || cnt2 !== 2'd1) begin n_err++; $display("FAIL drain_done got mm=%b cnt=%0d want 0/1", mm2, cnt2); end
      tick();
      n_vec++; if (mm2 !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b want 0", mm2); end
   endtask

   task automatic test_saturate();
      logic [1:0] want_cnt [5];
      want_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_clear();
      en = 1'b1;
      for (int k = 0; k < 7; k++) begin
         in1 = (k < 2) ? 4'hF : 4'h0;
         o2  = (k < 2) ? 1'bx : ((k < 4) ? 1'b0 : 1'b1);
         tick();
         if (k >= 2) begin
            n_vec++; if (mm2 !== 1'b1) begin n_err++; $display("FAIL sat_mm2[%0d] got %b want 1", k, mm2); end
            n_vec++; if (cnt2 !== want_cnt[k-2]) begin n_err++; $display("FAIL sat_cnt2[%0d] got %0d want %0d", k, cnt2, want_cnt[k-2]); end
            n_vec++; if (fe2 !== 1'b1 || ft2 !== 4'd2) begin n_err++; $display("FAIL sat_first[%0d] got exp=%b tag=%0d want 1/2", k, fe2, ft2); end
         end
      end
      en = 1'b0;
   endtask

   task automatic test_clear_collide();
      do_clear();
      en = 1'b1; in1 = 4'hF; o2 = 1'bx; o0 = 1'b1; tick(); tick();
      o2 = 1'b0; o0 = 1'b0; clear = 1'b1; tick();
      clear = 1'b0; en = 1'b0;
      n_vec++; if (mm2 !== 1'b0)  begin n_err++; $display("FAIL clr_mm2 got %b want 0", mm2); end
      n_vec++; if (cnt2 !== 2'd0) begin n_err++; $display("FAIL clr_cnt2 got %0d want 0", cnt2); end
      n_vec++; if (st2 !== 1'b0)  begin n_err++; $display("FAIL clr_st2 got %b want 0", st2); end
      n_vec++; if (ck2 !== 1'b0)  begin n_err++; $display("FAIL clr_ck2 got %b want 0", ck2); end
      n_vec++; if (mm0 !== 1'b0 || cnt0 !== 8'd0) begin n_err++; $display("FAIL clr_d0 got mm=%b cnt=%0d want 0/0", mm0, cnt0); end
      o2 = 1'bx; tick(); tick();
      n_vec++; if (mm2 !== 1'b0 || ck2 !== 1'b0) begin n_err++; $display("FAIL clr_idle got mm=%b ck=%b want 0/0", mm2, ck2); end
   endtask

   task automatic test_l1_xor();
      do_clear();
      en = 1'b1; in1 = 4'h3; o3 = 1'bx; tick();
      n_vec++; if (mm3 !== 1'b0 || ck3 !== 1'b0) begin n_err++; $display("FAIL xor_a got mm=%b ck=%b want 0/0", mm3, ck3); end
      in1 = 4'h7; o3 = 1'b0; tick();
      n_vec++; if (mm3 !== 1'b0 || ck3 !== 1'b1) begin n_err++; $display("FAIL xor_b got mm=%b ck=%b want 0/1", mm3, ck3); end
      in1 = 4'h1; o3 = 1'b0; tick();
      n_vec++; if (mm3 !== 1'b1) begin n_err++; $display("FAIL xor_c got %b want 1", mm3); end
      n_vec++; if (fe3 !== 1'b1 || ft3 !== 4'd2) begin n_err++; $display("FAIL xor_first got exp=%b tag=%0d want 1/2", fe3, ft3); end
      in1 = 4'h0; o3 = 1'b1; tick();
      n_vec++; if (mm3 !== 1'b0) begin n_err++; $display("FAIL xor_d got %b want 0", mm3); end
      o3 = 1'b1; tick();
      n_vec++; if (mm3 !== 1'b1 || cnt3 !== 8'd2) begin n_err++; $display("FAIL xor_e got mm=%b cnt=%0d want 1/2", mm3, cnt3); end
      n_vec++; if (fe3 !== 1'b1 || ft3 !== 4'd2) begin n_err++; $display("FAIL xor_frozen got exp=%b tag=%0d want 1/2", fe3, ft3); end
      en = 1'b0;
   endtask

   task automatic test_async_reset();
      do_clear();
      en = 1'b1; in1 = 4'hF; o2 = 1'b0; o0 = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      n_vec++; if (cnt2 !== 2'd3 || ck2 !== 1'b1) begin n_err++; $display("FAIL pre_rst got cnt=%0d ck=%b want 3/1", cnt2, ck2); end
      #3 rst_n = 1'b0;
      #1;
      n_vec++; if (mm2 !== 1'b0 || st2 !== 1'b0 || cnt2 !== 2'd0) begin n_err++; $display("FAIL arst_err got mm=%b st=%b cnt=%0d want 0/0/0", mm2, st2, cnt2); end
      n_vec++; if (fe2 !== 1'b0 || ft2 !== 4'd0 || ck2 !== 1'b0) begin n_err++; $display("FAIL arst_cap got fe=%b ft=%0d ck=%b want 0/0/0", fe2, ft2, ck2); end
      n_vec++; if (mm0 !== 1'b0 || cnt0 !== 8'd0) begin n_err++; $display("FAIL arst_d0 got mm=%b cnt=%0d want 0/0", mm0, cnt0); end
      tick();
      rst_n = 1'b1;
      tick();
      n_vec++; if (mm0 !== 1'b0 || mm2 !== 1'b0) begin n_err++; $display("FAIL rel_e1 got mm0=%b mm2=%b want 0/0", mm0, mm2); end
      tick();
      n_vec++; if (mm0 !== 1'b0 || cnt0 !== 8'd0) begin n_err++; $display("FAIL rel_e2 got mm=%b cnt=%0d want 0/0", mm0, cnt0); end
      tick(); tick();
      n_vec++; if (mm0 !== 1'b1) begin n_err++; $display("FAIL rel_e4 got %b want 1", mm0); end
      en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_l0_modes();
      test_l2_or();
      test_drain();
      test_saturate();
      test_clear_collide();
      test_l1_xor();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
